// File: rtl/divider_pkg.sv
// Shared types for the sequential restoring divider: FSM state encoding and
// the iteration-counter width helper.
package divider_pkg;

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

  // Counter runs N-1 down to 0, so it needs clog2(N) bits (at least one).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Operand/result bus of the sequential restoring divider.
interface seq_restoring_divider_if #(
  parameter int N = 32
) ();

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; the source holds its payload stable until that edge, and
  // valid never depends combinationally on ready.
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_sub_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when it does not borrow.
module div_sub_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] r,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] next_rem,
  output logic         qbit
);

  logic [N:0] t;

  assign t        = {1'b0, r} - {1'b0, divisor};
  assign qbit     = ~t[N];
  assign next_rem = t[N] ? r : t[N-1:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative N-bit restoring divider, one quotient bit per cycle.
// Define DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module seq_restoring_divider
  import divider_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seq_restoring_divider_if.slave  bus,
  output div_state_t              dbg_state
);

  localparam int CW = cnt_width(N);

  div_state_t    state, state_nxt;
  logic [CW-1:0] cnt;
  logic [N-1:0]  dq, rem, dvs;
  logic [N-1:0]  quo_q, rem_q;
  logic          dbz_q;
  logic [N-1:0]  step_r, step_rem, q_full;
  logic          step_qbit;
  logic          accept, div0;
  logic [N-1:0]  dividend_mag, divisor_mag, quo_fix, rem_fix;

  assign accept = (state == DIV_IDLE) && bus.in_valid;
  assign div0   = (bus.divisor == '0);
  // The partial remainder is always below 2^(N-1) before the shift, so the
  // dropped MSB is never significant.
  assign step_r = {rem[N-2:0], dq[N-1]};
  assign q_full = {dq[N-2:0], step_qbit};

`ifdef DIVIDER_SIGNED_EN
  logic neg_q, neg_r;

  assign dividend_mag = bus.dividend[N-1] ? -bus.dividend : bus.dividend;
  assign divisor_mag  = bus.divisor[N-1]  ? -bus.divisor  : bus.divisor;
  assign quo_fix      = neg_q ? -q_full   : q_full;
  assign rem_fix      = neg_r ? -step_rem : step_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= bus.dividend[N-1] ^ bus.divisor[N-1];
      neg_r <= bus.dividend[N-1];
    end
  end
`else
  assign dividend_mag = bus.dividend;
  assign divisor_mag  = bus.divisor;
  assign quo_fix      = q_full;
  assign rem_fix      = step_rem;
`endif

  div_sub_step #(.N(N)) u_step (
    .r        (step_r),
    .divisor  (dvs),
    .next_rem (step_rem),
    .qbit     (step_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DIV_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (bus.in_valid) state_nxt = div0 ? DIV_DONE : DIV_BUSY;
      DIV_BUSY: if (cnt == '0) state_nxt = DIV_DONE;
      DIV_DONE: if (bus.out_ready) state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
  end

  // Result registers load only on DONE entry so the working registers never leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      dq    <= '0;
      rem   <= '0;
      dvs   <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
    end else if (accept) begin
      cnt <= CW'(N - 1);
      rem <= '0;
      dq  <= dividend_mag;
      dvs <= divisor_mag;
      if (div0) begin
        quo_q <= '1;
        rem_q <= bus.dividend;
        dbz_q <= 1'b1;
      end
    end else if (state == DIV_BUSY) begin
      rem <= step_rem;
      dq  <= q_full;
      cnt <= cnt - CW'(1);
      if (cnt == '0) begin
        quo_q <= quo_fix;
        rem_q <= rem_fix;
        dbz_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = rst_n && (state == DIV_IDLE);
  assign bus.out_valid   = (state == DIV_DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: directed N=8 vectors with literal results,
// random N=32 operations, and a scoreboard fed by an arithmetic reference model.
module tb_seq_restoring_divider;
  import divider_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  seq_restoring_divider_if #(.N(8))  if8  ();
  seq_restoring_divider_if #(.N(32)) if32 ();
  div_state_t st8, st32;

  seq_restoring_divider #(.N(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (if8),
    .dbg_state (st8)
  );

  seq_restoring_divider #(.N(32)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (if32),
    .dbg_state (st32)
  );

  int errors = 0;
  int checks = 0;
  int acc8 = 0;
  int acc32 = 0;
  logic [64:0] exp8_q[$];
  logic [64:0] exp32_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // Reference: packs {div_by_zero, quotient, remainder} at width w, using
  // 64-bit arithmetic so MIN_INT / -1 wraps back to MIN_INT on truncation.
  function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b, input int w);
    longint sa, sb, q, r;
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if ((b & mask) == 32'd0) return {1'b1, mask, a & mask};
    sa = longint'(a);
    sb = longint'(b);
`ifdef DIVIDER_SIGNED_EN
    if (a[w-1]) sa = sa - (longint'(1) << w);
    if (b[w-1]) sb = sb - (longint'(1) << w);
`endif
    q = sa / sb;
    r = sa % sb;
    return {1'b0, 32'(q) & mask, 32'(r) & mask};
  endfunction

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (if8.out_valid) begin
        if (exp8_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL n8_unexpected_result: got q=%0h r=%0h expected none", if8.quotient, if8.remainder);
        end else begin
          chk("n8_model_q", 64'(if8.quotient), 64'(exp8_q[0][63:32]));
          chk("n8_model_r", 64'(if8.remainder), 64'(exp8_q[0][31:0]));
          chk("n8_model_dbz", 64'(if8.div_by_zero), 64'(exp8_q[0][64]));
          if (if8.out_ready) void'(exp8_q.pop_front());
        end
      end
      if (if32.out_valid) begin
        if (exp32_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL n32_unexpected_result: got q=%0h r=%0h expected none", if32.quotient, if32.remainder);
        end else begin
          chk("n32_model_q", 64'(if32.quotient), 64'(exp32_q[0][63:32]));
          chk("n32_model_r", 64'(if32.remainder), 64'(exp32_q[0][31:0]));
          chk("n32_model_dbz", 64'(if32.div_by_zero), 64'(exp32_q[0][64]));
          if (if32.out_ready) void'(exp32_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic accept8(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    while (!if8.in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!if8.in_ready) timeout("n8_in_ready");
    if8.dividend = a;
    if8.divisor  = b;
    if8.in_valid = 1'b1;
    exp8_q.push_back(model(32'(a), 32'(b), 8));
    @(posedge clk); #1;
    acc8 = cyc;
    if8.in_valid = 1'b0;
  endtask

  task automatic finish8(input logic [7:0] eq, input logic [7:0] er, input logic edbz, input int hold);
    int n = 0;
    while (!if8.out_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!if8.out_valid) timeout("n8_out_valid");
    chk("n8_latency", 64'(cyc - acc8 + 1), edbz ? 64'd1 : 64'd9);
    chk("n8_lit_q", 64'(if8.quotient), 64'(eq));
    chk("n8_lit_r", 64'(if8.remainder), 64'(er));
    chk("n8_lit_dbz", 64'(if8.div_by_zero), 64'(edbz));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("n8_hold_valid", 64'(if8.out_valid), 64'd1);
      chk("n8_hold_in_ready", 64'(if8.in_ready), 64'd0);
      chk("n8_hold_q", 64'(if8.quotient), 64'(eq));
      chk("n8_hold_r", 64'(if8.remainder), 64'(er));
    end
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    if8.out_ready = 1'b0;
    chk("n8_drained_valid", 64'(if8.out_valid), 64'd0);
    chk("n8_idle_in_ready", 64'(if8.in_ready), 64'd1);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                     input logic [7:0] er, input logic edbz, input int hold);
    accept8(a, b);
    finish8(eq, er, edbz, hold);
  endtask

  // Pulses a second operand pair during BUSY; it must be neither sampled nor queued.
  task automatic busy_drop(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq, input logic [7:0] er);
    accept8(a, b);
    repeat (2) begin @(posedge clk); #1; end
    if8.dividend = 8'd3;
    if8.divisor  = 8'd2;
    if8.in_valid = 1'b1;
    chk("n8_busy_in_ready", 64'(if8.in_ready), 64'd0);
    repeat (2) begin @(posedge clk); #1; end
    if8.in_valid = 1'b0;
    finish8(eq, er, 1'b0, 0);
    repeat (12) begin @(posedge clk); #1; end
    chk("n8_dropped_op_valid", 64'(if8.out_valid), 64'd0);
    chk("n8_dropped_op_state", 64'(st8), 64'(DIV_IDLE));
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!if32.in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!if32.in_ready) timeout("n32_in_ready");
    if32.dividend = a;
    if32.divisor  = b;
    if32.in_valid = 1'b1;
    exp32_q.push_back(model(a, b, 32));
    @(posedge clk); #1;
    acc32 = cyc;
    if32.in_valid = 1'b0;
    n = 0;
    while (!if32.out_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!if32.out_valid) timeout("n32_out_valid");
    chk("n32_latency", 64'(cyc - acc32 + 1), (b == 32'd0) ? 64'd1 : 64'd33);
`ifndef DIVIDER_SIGNED_EN
    if (b != 32'd0) begin
      chk("n32_invariant", 64'(if32.quotient) * 64'(b) + 64'(if32.remainder), 64'(a));
      chk("n32_rem_lt_div", 64'(if32.remainder < b), 64'd1);
    end
`endif
    if32.out_ready = 1'b1;
    @(posedge clk); #1;
    if32.out_ready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    if8.in_valid  = 1'b0;
    if8.dividend  = '0;
    if8.divisor   = '0;
    if8.out_ready = 1'b0;
    if32.in_valid  = 1'b0;
    if32.dividend  = '0;
    if32.divisor   = '0;
    if32.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(if8.in_ready), 64'd0);
    chk("rst_out_valid", 64'(if8.out_valid), 64'd0);
    chk("rst_q", 64'(if8.quotient), 64'd0);
    chk("rst_r", 64'(if8.remainder), 64'd0);
    chk("rst_dbz", 64'(if8.div_by_zero), 64'd0);
    chk("rst_state", 64'(st8), 64'(DIV_IDLE));
    chk("rst_n32_out_valid", 64'(if32.out_valid), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(if8.in_ready), 64'd1);

    op8(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 0);
    op8(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 0);
    op8(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 5);
    op8(8'd0, 8'd9, 8'd0, 8'd0, 1'b0, 5);
    op8(8'd7, 8'd7, 8'd1, 8'd0, 1'b0, 0);
    op8(8'd6, 8'd200, 8'd0, 8'd6, 1'b0, 0);
`ifdef DIVIDER_SIGNED_EN
    op8(8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 0);
    op8(8'd7, 8'hFE, 8'hFD, 8'd1, 1'b0, 0);
    op8(8'h80, 8'hFF, 8'h80, 8'd0, 1'b0, 0);
    op8(8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, 0);
    busy_drop(8'd100, 8'd3, 8'd33, 8'd1);
`else
    op8(8'd255, 8'd16, 8'd15, 8'd15, 1'b0, 0);
    op8(8'd128, 8'd129, 8'd0, 8'd128, 1'b0, 0);
    busy_drop(8'd200, 8'd3, 8'd66, 8'd2);
`endif

    // Abort in the middle of an operation.
    accept8(8'd100, 8'd7);
    repeat (4) begin @(posedge clk); #1; end
    chk("abort_pre_state", 64'(st8), 64'(DIV_BUSY));
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(if8.out_valid), 64'd0);
    chk("abort_in_ready", 64'(if8.in_ready), 64'd0);
    chk("abort_state", 64'(st8), 64'(DIV_IDLE));
    exp8_q.delete();
    exp32_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    op8(8'd9, 8'd4, 8'd2, 8'd1, 1'b0, 0);

    // Wide operands.
    op32(32'hFFFF_FFFF, 32'd1);
    op32(32'd1000, 32'd0);
    op32(32'h8000_0000, 32'hFFFF_FFFF);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      int k;
      a = $urandom;
      k = $urandom_range(0, 9);
      case (k)
        0:       b = 32'd0;
        1, 2, 3: b = 32'($urandom_range(1, 255));
        4:       b = 32'd1;
        5:       b = a;
        default: b = $urandom;
      endcase
      op32(a, b);
    end

    repeat (3) begin @(posedge clk); #1; end
    chk("n8_queue_empty", 64'(exp8_q.size()), 64'd0);
    chk("n32_queue_empty", 64'(exp32_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
